// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an iterative
// shift-add unsigned multiply. Define ALU_MC_MULT_HI_EN to produce the product high word.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [3:0]            OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic [DATA_WIDTH-1:0] OUT_HI,
  output logic                  ZERO,
  output logic                  CARRY,
  output logic                  OVF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int W  = DATA_WIDTH;
`ifdef ALU_MC_MULT_HI_EN
  localparam int AW = 2 * W;
`else
  localparam int AW = W;
`endif
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [W-1:0]  W_AMT     = W'(W);

  typedef enum logic [3:0] {
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_MUL = 4'h3,
    OP_SRL = 4'h4,
    OP_SLL = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_NOR = 4'h8,
    OP_SLT = 4'h9
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    out_q, out_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   acc_step;
`ifdef ALU_MC_MULT_HI_EN
  logic [W-1:0]    hi_q, hi_d;
`endif

  logic [W:0]      add_full;
  logic [W-1:0]    sub_res;
  logic [W-1:0]    alu_res;
  logic            alu_carry;
  logic            alu_ovf;

  // Single-cycle datapath, evaluated directly on the live operands at the capture edge
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    add_full  = {1'b0, OP1} + {1'b0, OP2};
    sub_res   = OP1 - OP2;
    case (OPRN)
      OP_ADD: begin
        alu_res   = add_full[W-1:0];
        alu_carry = add_full[W];
        alu_ovf   = (OP1[W-1] == OP2[W-1]) && (add_full[W-1] != OP1[W-1]);
      end
      OP_SUB: begin
        alu_res   = sub_res;
        alu_carry = (OP1 >= OP2);
        alu_ovf   = (OP1[W-1] != OP2[W-1]) && (sub_res[W-1] != OP1[W-1]);
      end
      OP_SRL:  alu_res = (OP2 >= W_AMT) ? '0 : (OP1 >> OP2);
      OP_SLL:  alu_res = (OP2 >= W_AMT) ? '0 : (OP1 << OP2);
      OP_AND:  alu_res = OP1 & OP2;
      OP_OR:   alu_res = OP1 | OP2;
      OP_NOR:  alu_res = ~(OP1 | OP2);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`ifdef ALU_MC_MULT_HI_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (OPRN == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = AW'(OP1);
            mplier_d = OP2;
            acc_d    = '0;
          end else begin
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
            done_d  = 1'b1;
`ifdef ALU_MC_MULT_HI_EN
            hi_d    = '0;
`endif
          end
        end
      end
      S_MUL: begin
        // Partial products stay in acc; OUT only updates on the final iteration
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          out_d   = acc_step[W-1:0];
          zero_d  = (acc_step[W-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
`ifdef ALU_MC_MULT_HI_EN
          hi_d    = acc_step[AW-1:W];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

`ifdef ALU_MC_MULT_HI_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hi_q <= '0;
    else     hi_q <= hi_d;
  end
  assign OUT_HI = hi_q;
`else
  assign OUT_HI = '0;
`endif

  assign OUT   = out_q;
  assign ZERO  = zero_q;
  assign CARRY = carry_q;
  assign OVF   = ovf_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle against a plain-arithmetic model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [3:0]   OPRN = '0;
  logic [W-1:0] OP1 = '0;
  logic [W-1:0] OP2 = '0;
  logic [W-1:0] OUT;
  logic [W-1:0] OUT_HI;
  logic         ZERO, CARRY, OVF, BUSY, DONE;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  res_t last;
  localparam res_t RESET_RES = '{lo: '0, hi: '0, z: 1'b1, c: 1'b0, v: 1'b0};

  alu_multicycle #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
    .OUT(OUT), .OUT_HI(OUT_HI), .ZERO(ZERO), .CARRY(CARRY), .OVF(OVF),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint unsigned ua, ub, p;
    longint sa, sb, t;
    longint smax, smin;
    r    = '0;
    ua   = a;
    ub   = b;
    sa   = $signed(a);
    sb   = $signed(b);
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    case (op)
      4'h1: begin
        p    = ua + ub;
        r.lo = p[W-1:0];
        r.c  = p[W];
        t    = sa + sb;
        r.v  = (t > smax) || (t < smin);
      end
      4'h2: begin
        p    = ua - ub;
        r.lo = p[W-1:0];
        r.c  = (ua >= ub);
        t    = sa - sb;
        r.v  = (t > smax) || (t < smin);
      end
      4'h3: begin
        p    = ua * ub;
        r.lo = p[W-1:0];
`ifdef ALU_MC_MULT_HI_EN
        r.hi = p[2*W-1:W];
`endif
      end
      4'h4: begin p = (ub >= W) ? 0 : (ua >> ub); r.lo = p[W-1:0]; end
      4'h5: begin p = (ub >= W) ? 0 : (ua << ub); r.lo = p[W-1:0]; end
      4'h6: r.lo = a & b;
      4'h7: r.lo = a | b;
      4'h8: r.lo = ~(a | b);
      4'h9: r.lo = (sa < sb) ? 1 : 0;
      default: r.lo = '0;
    endcase
    r.z = (r.lo == '0);
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    check_eq({tag, "_out"},    64'(OUT),    64'(e.lo));
    check_eq({tag, "_out_hi"}, 64'(OUT_HI), 64'(e.hi));
    check_eq({tag, "_zero"},   64'(ZERO),   64'(e.z));
    check_eq({tag, "_carry"},  64'(CARRY),  64'(e.c));
    check_eq({tag, "_ovf"},    64'(OVF),    64'(e.v));
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    res_t e;
    int   edges;
    e = model(op, a, b);
    @(negedge CLK);
    START = 1'b1; OPRN = op; OP1 = a; OP2 = b;
    @(posedge CLK); #1;
    START = 1'b0; OPRN = 4'($urandom); OP1 = $urandom; OP2 = $urandom;
    if (op == 4'h3) begin
      check_eq({tag, "_busy_cap"}, 64'(BUSY), 64'd1);
      check_eq({tag, "_done_cap"}, 64'(DONE), 64'd0);
      check_res({tag, "_hold"}, last);
      edges = 0;
      while (DONE !== 1'b1 && edges < W + 4) begin
        if (inject && edges == 4) begin
          @(negedge CLK);
          START = 1'b1; OPRN = 4'h1; OP1 = $urandom; OP2 = $urandom;
        end
        @(posedge CLK); #1;
        START = 1'b0;
        edges++;
        if (edges == 10) check_eq({tag, "_partial"}, 64'(OUT), 64'(last.lo));
      end
      check_eq({tag, "_latency"}, 64'(edges), 64'(W));
      check_eq({tag, "_busy_end"}, 64'(BUSY), 64'd0);
    end else begin
      check_eq({tag, "_done"}, 64'(DONE), 64'd1);
      check_eq({tag, "_busy"}, 64'(BUSY), 64'd0);
    end
    check_res(tag, e);
    last = e;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      check_eq("idle_done", 64'(DONE), 64'd0);
      check_eq("idle_hold", 64'(OUT), 64'(last.lo));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           done_seen;

    last = RESET_RES;
    repeat (3) @(posedge CLK);
    #1;
    check_res("reset", RESET_RES);
    check_eq("reset_busy", 64'(BUSY), 64'd0);
    check_eq("reset_done", 64'(DONE), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle_cycles(2);

    run_op("add_ovf", 4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_eq",  4'h2, 32'd5, 32'd5, 1'b0);
    run_op("sub_neg", 4'h2, 32'd3, 32'd5, 1'b0);
    run_op("mul_max", 4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("slt_a",   4'h9, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    run_op("slt_b",   4'h9, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("sll_40",  4'h5, 32'd1, 32'd40, 1'b0);
    run_op("srl_31",  4'h4, 32'h8000_0000, 32'd31, 1'b0);
    run_op("sll_32",  4'h5, 32'hFFFF_FFFF, 32'd32, 1'b0);
    run_op("illegal", 4'hF, 32'h1234_5678, 32'h1, 1'b0);
    run_op("mul_sm",  4'h3, 32'd12345, 32'd678, 1'b0);
    idle_cycles(3);

    // Abort a multiply with reset part-way through
    @(negedge CLK);
    START = 1'b1; OPRN = 4'h3; OP1 = 32'hDEAD_BEEF; OP2 = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    check_eq("rst_mul_busy", 64'(BUSY), 64'd1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_res("rst_abort", RESET_RES);
    check_eq("rst_abort_busy", 64'(BUSY), 64'd0);
    check_eq("rst_abort_done", 64'(DONE), 64'd0);
    last = RESET_RES;
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) done_seen++;
    end
    check_eq("rst_no_done", 64'(done_seen), 64'd0);
    check_res("rst_after", RESET_RES);
    run_op("and_after_rst", 4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = W'($urandom_range(0, 40));
        2: a = {1'b0, {(W-1){1'b1}}};
        3: a = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      run_op("rand", op, a, b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
